// File: rtl/tpu_pkg.sv
// Shared types and helpers for the systolic MAC array.
// Provides the FSM state enum, the saturating/wrapping add and width helpers.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DRAIN
    } state_t;

    // Wide enough to hold any accumulator plus product without loss.
    localparam int SUM_W = 64;

    typedef struct packed {
        logic             ovf;
        logic [SUM_W-1:0] val;
    } add_res_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Adds in full precision, then flags results outside the signed
    // 'bits'-wide range. With sat set the result is clamped; otherwise
    // the caller keeps the low bits, which is a two's-complement wrap.
    function automatic add_res_t sat_add(
        input logic signed [SUM_W-1:0] acc,
        input logic signed [SUM_W-1:0] prod,
        input int                      bits,
        input logic                    sat
    );
        logic signed [SUM_W-1:0] sum;
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        add_res_t                r;
        sum   = acc + prod;
        hi    = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (bits - 1));
        r.ovf = (sum > hi) || (sum < lo);
        r.val = sum;
        if (r.ovf && sat)
            r.val = (sum > hi) ? hi : lo;
        return r;
    endfunction

endpackage

// File: rtl/systolic_mac_array_pe.sv
// One output-stationary MAC cell: registers a/b, forwards them, accumulates.
// Ports: i_en/i_clr control, i_a/i_b in, o_a/o_b forwarded, o_acc, o_ovf pulse.
module systolic_pe
    import tpu_pkg::*;
#(
    parameter int BITS_AB  = 8,
    parameter int BITS_C   = 16,
    parameter int SATURATE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_en,
    input  logic                      i_clr,
    input  logic signed [BITS_AB-1:0] i_a,
    input  logic signed [BITS_AB-1:0] i_b,
    output logic signed [BITS_AB-1:0] o_a,
    output logic signed [BITS_AB-1:0] o_b,
    output logic signed [BITS_C-1:0]  o_acc,
    output logic                      o_ovf
);

    localparam int PW = 2 * BITS_AB;

    logic signed [BITS_AB-1:0] r_a;
    logic signed [BITS_AB-1:0] r_b;
    logic signed [BITS_C-1:0]  r_acc;
    logic signed [PW-1:0]      w_prod;
    add_res_t                  w_res;
    logic                      w_unused_hi;

    assign w_prod = PW'(r_a) * PW'(r_b);
    assign w_res  = sat_add(SUM_W'(r_acc), SUM_W'(w_prod),
                            BITS_C, SATURATE != 0);
    assign w_unused_hi = ^w_res.val[SUM_W-1:BITS_C];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_clr) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_en) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= w_res.val[BITS_C-1:0];
        end
    end

    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;
    assign o_ovf = i_en && !i_clr && w_res.ovf;

endmodule

// File: rtl/systolic_mac_array.sv
// DIM x DIM output-stationary systolic array computing C = A*B.
// Ports: start/k_len job control, a_vec/b_vec beat stream, out_row drain, ovf.
module systolic_mac_array
    import tpu_pkg::*;
#(
    parameter int BITS_AB  = 8,
    parameter int BITS_C   = 16,
    parameter int DIM      = 4,
    parameter int K_MAX    = 255,
    parameter int SATURATE = 1,
    parameter int KW       = $clog2(K_MAX + 1),
    parameter int IW       = $clog2(DIM)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [KW-1:0]           k_len,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIM*BITS_AB-1:0]  a_vec,
    input  logic [DIM*BITS_AB-1:0]  b_vec,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIM*BITS_C-1:0]   out_row,
    output logic [IW-1:0]           out_idx,
    output logic                    out_last,
    output logic                    ovf
);

    localparam int CW = imax(KW, $clog2(2 * DIM));

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;
    logic            r_ovf;
    logic            w_clr;
    logic            w_en;
    logic            w_beat;
    logic            w_out_hs;

    logic signed [BITS_AB-1:0] w_a   [DIM][DIM+1];
    logic signed [BITS_AB-1:0] w_b   [DIM+1][DIM];
    logic signed [BITS_C-1:0]  w_acc [DIM][DIM];
    logic [DIM*DIM-1:0]        w_ovf;
    logic [DIM-1:0]            w_unused_a;
    logic [DIM-1:0]            w_unused_b;

    assign w_beat   = in_valid && (r_state == STREAM);
    assign w_en     = w_beat || (r_state == FLUSH);
    assign w_out_hs = (r_state == DRAIN) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_clr  = 1'b1;
                    w_next = (k_len == '0) ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (w_beat && r_cnt == CW'(1))
                    w_next = FLUSH;
            end
            FLUSH: begin
                // 2*DIM-1 cycles lets the last pair reach PE(DIM-1,DIM-1).
                if (r_cnt == CW'(2 * DIM - 2))
                    w_next = DRAIN;
            end
            DRAIN: begin
                if (w_out_hs && r_idx == IW'(DIM - 1))
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // r_cnt counts remaining beats in STREAM, then elapsed cycles in FLUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_ovf <= 1'b0;
        end else if (w_clr) begin
            r_cnt <= CW'(k_len);
            r_idx <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_beat)
                r_cnt <= r_cnt - CW'(1);
            else if (r_state == FLUSH)
                r_cnt <= r_cnt + CW'(1);
            if (w_out_hs)
                r_idx <= (r_idx == IW'(DIM - 1)) ? '0 : r_idx + IW'(1);
            if (|w_ovf)
                r_ovf <= 1'b1;
        end
    end

    genvar i, j;
    generate
        for (i = 0; i < DIM; i++) begin : g_skew
            logic signed [BITS_AB-1:0] w_ain;
            logic signed [BITS_AB-1:0] w_bin;
            // Outside STREAM the array only advances in FLUSH: feed zeros.
            assign w_ain = (r_state == STREAM) ?
                           a_vec[i*BITS_AB +: BITS_AB] : '0;
            assign w_bin = (r_state == STREAM) ?
                           b_vec[i*BITS_AB +: BITS_AB] : '0;
            if (i == 0) begin : g_d0
                assign w_a[0][0] = w_ain;
                assign w_b[0][0] = w_bin;
            end else begin : g_dn
                logic signed [BITS_AB-1:0] r_sa [i];
                logic signed [BITS_AB-1:0] r_sb [i];
                always_ff @(posedge clk or posedge rst) begin
                    if (rst || w_clr) begin
                        for (int n = 0; n < i; n++) begin
                            r_sa[n] <= '0;
                            r_sb[n] <= '0;
                        end
                    end else if (w_en) begin
                        r_sa[0] <= w_ain;
                        r_sb[0] <= w_bin;
                        for (int n = 1; n < i; n++) begin
                            r_sa[n] <= r_sa[n-1];
                            r_sb[n] <= r_sb[n-1];
                        end
                    end
                end
                assign w_a[i][0] = r_sa[i-1];
                assign w_b[0][i] = r_sb[i-1];
            end
            assign w_unused_a[i] = ^w_a[i][DIM];
            assign w_unused_b[i] = ^w_b[DIM][i];
        end

        for (i = 0; i < DIM; i++) begin : g_row
            for (j = 0; j < DIM; j++) begin : g_col
                systolic_pe #(
                    .BITS_AB  (BITS_AB),
                    .BITS_C   (BITS_C),
                    .SATURATE (SATURATE)
                ) u_pe (
                    .clk   (clk),
                    .rst   (rst),
                    .i_en  (w_en),
                    .i_clr (w_clr),
                    .i_a   (w_a[i][j]),
                    .i_b   (w_b[i][j]),
                    .o_a   (w_a[i][j+1]),
                    .o_b   (w_b[i+1][j]),
                    .o_acc (w_acc[i][j]),
                    .o_ovf (w_ovf[i*DIM+j])
                );
            end
        end
    endgenerate

    always_comb begin
        out_row = '0;
        if (r_state == DRAIN) begin
            for (int c = 0; c < DIM; c++)
                out_row[c*BITS_C +: BITS_C] = w_acc[r_idx][c];
        end
    end

    assign busy      = (r_state != IDLE);
    assign in_ready  = (r_state == STREAM);
    assign out_valid = (r_state == DRAIN);
    assign out_idx   = r_idx;
    assign out_last  = (r_state == DRAIN) && (r_idx == IW'(DIM - 1));
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array: saturating and wrapping DUTs
// share stimulus and are checked every drain cycle against a matrix model.
module tb_systolic_mac_array;

    localparam int DIM  = 4;
    localparam int BA   = 8;
    localparam int BC   = 16;
    localparam int KMAX = 255;
    localparam int KW   = $clog2(KMAX + 1);
    localparam int IW   = $clog2(DIM);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [KW-1:0]     k_len;
    logic              in_valid;
    logic              out_ready;
    logic [DIM*BA-1:0] a_vec;
    logic [DIM*BA-1:0] b_vec;

    logic              busy_s, in_ready_s, out_valid_s, out_last_s, ovf_s;
    logic              busy_w, in_ready_w, out_valid_w, out_last_w, ovf_w;
    logic [DIM*BC-1:0] out_row_s, out_row_w;
    logic [IW-1:0]     out_idx_s, out_idx_w;

    systolic_mac_array #(.BITS_AB(BA), .BITS_C(BC), .DIM(DIM),
                         .K_MAX(KMAX), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy_s), .in_valid(in_valid), .in_ready(in_ready_s),
        .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_row(out_row_s), .out_idx(out_idx_s),
        .out_last(out_last_s), .ovf(ovf_s)
    );

    systolic_mac_array #(.BITS_AB(BA), .BITS_C(BC), .DIM(DIM),
                         .K_MAX(KMAX), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy_w), .in_valid(in_valid), .in_ready(in_ready_w),
        .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_row(out_row_w), .out_idx(out_idx_w),
        .out_last(out_last_w), .ovf(ovf_w)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    int ma [DIM][8];
    int mb [8][DIM];
    int es [DIM][DIM];
    int ew [DIM][DIM];
    bit eos, eow;

    // C = A*B accumulated in k order, once clamped and once wrapped.
    task automatic model(input int k);
        int p, s, w, as, aw;
        eos = 0;
        eow = 0;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                as = 0;
                aw = 0;
                for (int kk = 0; kk < k; kk++) begin
                    p = ma[i][kk] * mb[kk][j];
                    s = as + p;
                    if (s > 32767) begin s = 32767; eos = 1; end
                    if (s < -32768) begin s = -32768; eos = 1; end
                    as = s;
                    w = aw + p;
                    if (w > 32767 || w < -32768) eow = 1;
                    aw = ((w + 32768 + 65536) % 65536) - 32768;
                end
                es[i][j] = as;
                ew[i][j] = aw;
            end
    endtask

    bit chk_on = 0;
    int exp_idx = 0;

    always @(negedge clk) begin
        if (chk_on && exp_idx < DIM) begin
            if (out_valid_s) begin
                chk("s_idx", out_idx_s, exp_idx);
                chk("s_last", out_last_s, exp_idx == DIM - 1);
                chk("s_ovf", ovf_s, eos);
                for (int j = 0; j < DIM; j++)
                    chk("s_row", longint'($signed(out_row_s[j*BC +: BC])),
                        es[exp_idx][j]);
            end
            if (out_valid_w) begin
                chk("w_idx", out_idx_w, exp_idx);
                chk("w_last", out_last_w, exp_idx == DIM - 1);
                chk("w_ovf", ovf_w, eow);
                for (int j = 0; j < DIM; j++)
                    chk("w_row", longint'($signed(out_row_w[j*BC +: BC])),
                        ew[exp_idx][j]);
            end
            if (out_valid_s && out_ready)
                exp_idx++;
        end
    end

    task automatic drive_beat(input int kk);
        for (int i = 0; i < DIM; i++) begin
            a_vec[i*BA +: BA] = BA'(ma[i][kk]);
            b_vec[i*BA +: BA] = BA'(mb[kk][i]);
        end
    endtask

    task automatic push_beats(input int n, input bit bub);
        int guard;
        for (int kk = 0; kk < n; kk++) begin
            in_valid = 0;
            repeat (bub ? (kk * 3) % 4 : 0) begin
                @(posedge clk);
                #1;
            end
            drive_beat(kk);
            in_valid = 1;
            guard = 0;
            while (!in_ready_s && guard < 50) begin
                @(posedge clk);
                #1;
                guard++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 0;
    endtask

    task automatic run_job(input int k, input bit bub, input int hold_n,
                           input bit poke, input bit lat);
        int c0, guard, rows, held;
        bit hs;
        model(k);
        exp_idx = 0;
        chk_on = 1;
        start = 1;
        k_len = KW'(k);
        @(posedge clk);
        #1;
        start = 0;
        chk("busy_start", busy_s, 1);
        chk("in_ready_start", in_ready_s, k > 0);
        push_beats(k, bub);
        c0 = cyc;
        if (lat) begin
            guard = 0;
            while (!out_valid_s && guard < 100) begin
                @(posedge clk);
                #1;
                guard++;
            end
            chk("latency", cyc - (c0 - 1), 2 * DIM);
        end
        rows = 0;
        held = 0;
        guard = 0;
        while (rows < DIM && guard < 300) begin
            if (out_valid_s && out_idx_s == IW'(2) && held < hold_n) begin
                out_ready = 0;
                held++;
                chk("hold_idx", out_idx_s, 2);
            end else begin
                out_ready = 1;
            end
            start = poke && out_valid_s && out_idx_s == IW'(1);
            k_len = KW'(3);
            hs = out_valid_s && out_ready;
            @(posedge clk);
            #1;
            start = 0;
            guard++;
            if (hs) rows++;
        end
        out_ready = 0;
        chk("rows", rows, DIM);
        chk("held", held, hold_n);
        chk("busy_end_s", busy_s, 0);
        chk("busy_end_w", busy_w, 0);
        chk("valid_end", out_valid_s, 0);
        chk("ovf_end_s", ovf_s, eos);
        chk("ovf_end_w", ovf_w, eow);
        chk_on = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy_s | busy_w, 0);
        chk({tag, "_in_ready"}, in_ready_s | in_ready_w, 0);
        chk({tag, "_out_valid"}, out_valid_s | out_valid_w, 0);
        chk({tag, "_out_row"}, (|out_row_s) | (|out_row_w), 0);
        chk({tag, "_out_idx"}, out_idx_s | out_idx_w, 0);
        chk({tag, "_out_last"}, out_last_s | out_last_w, 0);
        chk({tag, "_ovf"}, ovf_s | ovf_w, 0);
    endtask

    task automatic load_identity();
        for (int i = 0; i < DIM; i++)
            for (int kk = 0; kk < DIM; kk++) begin
                ma[i][kk] = (i == kk) ? 1 : 0;
                mb[kk][i] = kk * DIM + i + 1;
            end
    endtask

    initial begin
        rst = 1;
        start = 0;
        k_len = '0;
        in_valid = 0;
        out_ready = 0;
        a_vec = '0;
        b_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 0;
        @(posedge clk);
        #1;
        check_zero("idle");

        for (int i = 0; i < DIM; i++) begin
            ma[i][0] = i + 1;
            mb[0][i] = 1;
        end
        run_job(1, 0, 0, 0, 1);
        chk("model_row3", es[3][2], 4);
        chk("model_row0", ew[0][1], 1);

        load_identity();
        run_job(4, 1, 0, 0, 1);
        chk("model_ident", es[2][1], 10);

        for (int i = 0; i < DIM; i++)
            for (int kk = 0; kk < DIM; kk++) begin
                ma[i][kk] = 127;
                mb[kk][i] = 127;
            end
        run_job(4, 0, 0, 0, 1);
        chk("model_sat", es[1][1], 32767);
        chk("model_wrap", ew[1][1], -1020);
        chk("model_ovf", eos & eow, 1);

        run_job(0, 0, 0, 0, 0);
        chk("model_zero", es[3][3], 0);

        for (int i = 0; i < DIM; i++) begin
            ma[i][0] = -128;
            mb[0][i] = (i % 2 == 0) ? -128 : 127;
        end
        run_job(1, 0, 0, 0, 1);
        chk("model_negneg", es[0][0], 16384);
        chk("model_negpos", es[0][1], -16256);

        for (int i = 0; i < DIM; i++)
            for (int kk = 0; kk < 2; kk++) begin
                ma[i][kk] = i - kk * 3;
                mb[kk][i] = 2 * i + kk - 1;
            end
        run_job(2, 0, 5, 1, 1);
        chk("model_mix", es[2][3], 5 * 2 + (-1) * 6);

        for (int i = 0; i < DIM; i++)
            for (int kk = 0; kk < 5; kk++) begin
                ma[i][kk] = 127;
                mb[kk][i] = 127;
            end
        start = 1;
        k_len = KW'(5);
        @(posedge clk);
        #1;
        start = 0;
        push_beats(4, 0);
        chk("ovf_mid_job", ovf_s, 1);
        rst = 1;
        #1;
        check_zero("midrst");
        @(posedge clk);
        #1;
        rst = 0;
        @(posedge clk);
        #1;
        check_zero("postrst");

        load_identity();
        run_job(4, 1, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
